// File: rtl/i2s_ser.sv
// i2s_ser: parallel-to-I2S master transmitter.
//
// Accepts 64-bit stereo words ([63:32] left, [31:0] right, MSB-aligned) over a
// valid/ready handshake into a single holding register. It generates BCK, LRCK
// and MSB-first serial data from the master clock, with the standard I2S one-bit
// delay. One frame is 64 BCK periods, and each BCK period is 2*BCK_HALF clk cycles.
//
// Ports:
//   clk       master clock (sole clock)
//   resetn    asynchronous active-low reset
//   en        run request; on deassertion the current frame is completed first
//   bitnum    word length, sampled at frame load: 00=16b, 01=24b, 10/11=32b
//   data      stereo word, left in [63:32] and right in [31:0]
//   valid     data valid
//   ready     holding register empty; a word transfers on valid && ready
//   bck       bit clock
//   lrck      word select (0 = left, 1 = right)
//   sdata     serial data, which changes only on BCK falling edges
//   underrun  one-clk pulse when a frame is loaded while no sample is held
//   busy      transmitter not idle
//
// Configuration macro:
//   I2S_SER_UNDERRUN_REPEAT_EN  when defined, an underrun repeats the previously
//                               loaded frame instead of sending digital silence.

module i2s_ser #(
  parameter int unsigned BCK_HALF = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic [1:0]  bitnum,
  input  logic [63:0] data,
  input  logic        valid,
  output logic        ready,
  output logic        bck,
  output logic        lrck,
  output logic        sdata,
  output logic        underrun,
  output logic        busy
);

  localparam int unsigned DivW = $clog2(2 * BCK_HALF);
  localparam logic [DivW-1:0] DivMax  = DivW'(2 * BCK_HALF - 1);
  localparam logic [DivW-1:0] BckHalf = DivW'(BCK_HALF);

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [5:0]      k_q, k_d;
  logic            bck_q, bck_d;
  logic            sdata_q, sdata_d;
  logic            underrun_q, underrun_d;
  logic [63:0]     hold_q, hold_d;
  logic            full_q, full_d;
  logic [63:0]     frame_q, frame_d;

  logic        div_wrap;
  logic        frame_end;
  logic        counting;
  logic        load;
  logic        stop_now;
  logic        accept;
  logic [5:0]  bit_idx;
  logic [31:0] ch_mask;
  logic [63:0] masked_hold;
  logic [63:0] underrun_fill;

  // The divider wrap is the BCK falling edge; frame_end is the falling edge that
  // leaves k=63.
  assign div_wrap  = (div_q == DivMax);
  assign frame_end = div_wrap && (k_q == 6'd63);
  assign accept    = valid && !full_q;

  always_comb begin
    case (bitnum)
      2'b00:   ch_mask = 32'hFFFF_0000;
      2'b01:   ch_mask = 32'hFFFF_FF00;
      default: ch_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign masked_hold = hold_q & {ch_mask, ch_mask};

`ifdef I2S_SER_UNDERRUN_REPEAT_EN
  assign underrun_fill = frame_q;
`else
  assign underrun_fill = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (en) state_d = StRun;
      StRun:  if (!en) state_d = StStop;
      StStop: begin
        if (en) begin
          state_d = StRun;
        end else if (frame_end) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM control outputs
  always_comb begin
    counting = 1'b0;
    load     = 1'b0;
    stop_now = 1'b0;
    unique case (state_q)
      StIdle: load = en;
      StRun: begin
        counting = 1'b1;
        load     = frame_end;
      end
      StStop: begin
        counting = 1'b1;
        load     = frame_end && en;
        stop_now = frame_end && !en;
      end
      default: ;
    endcase
  end

  // Datapath next state
  always_comb begin
    div_d      = div_q;
    k_d        = k_q;
    bck_d      = bck_q;
    sdata_d    = sdata_q;
    hold_d     = hold_q;
    full_d     = full_q;
    frame_d    = frame_q;
    bit_idx    = '0;
    underrun_d = load && !full_q;

    if (!counting || stop_now) begin
      div_d   = '0;
      k_d     = '0;
      bck_d   = 1'b0;
      sdata_d = 1'b0;
    end else begin
      div_d = div_wrap ? '0 : div_q + 1'b1;
      if (div_wrap) begin
        k_d = k_q + 6'd1;
        // Bit (64-k) mod 64 of the frame still in frame_q: at k=0 this is the
        // outgoing frame's LSB, which is sent before the new frame takes over.
        bit_idx = 6'd0 - k_d;
        sdata_d = frame_q[bit_idx];
      end
      bck_d = (div_d >= BckHalf);
    end

    if (load) begin
      full_d  = 1'b0;
      frame_d = full_q ? masked_hold : underrun_fill;
    end
    // Accept follows load, so a word arriving on the load edge waits one frame.
    if (accept) begin
      hold_d = data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_q      <= '0;
      k_q        <= '0;
      bck_q      <= 1'b0;
      sdata_q    <= 1'b0;
      underrun_q <= 1'b0;
      hold_q     <= '0;
      full_q     <= 1'b0;
      frame_q    <= '0;
    end else begin
      div_q      <= div_d;
      k_q        <= k_d;
      bck_q      <= bck_d;
      sdata_q    <= sdata_d;
      underrun_q <= underrun_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      frame_q    <= frame_d;
    end
  end

  assign ready    = !full_q;
  assign bck      = bck_q;
  assign lrck     = k_q[5];
  assign sdata    = sdata_q;
  assign underrun = underrun_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_i2s_ser.sv
// Self-checking bench for i2s_ser: a frame-level reference model pushes every
// expected transmitted frame into a queue, and an I2S receiver process rebuilds
// frames from bck/lrck/sdata and compares them with the queue. Per-cycle pin
// expectations come from the model's position within the frame.

module tb_i2s_ser;

  localparam int unsigned BckHalf  = 4;
  localparam int unsigned BckClk   = 2 * BckHalf;
  localparam int unsigned FrameClk = 64 * BckClk;

  logic        clk    = 1'b0;
  logic        resetn = 1'b0;
  logic        en     = 1'b0;
  logic [1:0]  bitnum = 2'b10;
  logic [63:0] data   = '0;
  logic        valid  = 1'b0;
  logic        ready, bck, lrck, sdata, underrun, busy;

  int checks = 0;
  int errors = 0;

  i2s_ser #(.BCK_HALF(BckHalf)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .bitnum   (bitnum),
    .data     (data),
    .valid    (valid),
    .ready    (ready),
    .bck      (bck),
    .lrck     (lrck),
    .sdata    (sdata),
    .underrun (underrun),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit          m_run, m_full, m_prev_ok, m_prev_b0, m_en_prev, m_und;
  int          m_cnt;  // clk cycles since the last frame load
  logic [63:0] m_hold, m_cur;
  logic [63:0] exp_q[$];

  function automatic logic [63:0] mask_word(input logic [63:0] w, input logic [1:0] bn);
    int drop;
    logic [31:0] l, r;
    drop = (bn == 2'b00) ? 16 : (bn == 2'b01) ? 8 : 0;
    l = w[63:32];
    r = w[31:0];
    l = (l >> drop) << drop;
    r = (r >> drop) << drop;
    return {l, r};
  endfunction

  task automatic m_reset();
    m_run = 0; m_full = 0; m_prev_ok = 0; m_prev_b0 = 0; m_en_prev = 0; m_und = 0;
    m_cnt = 0; m_hold = '0; m_cur = '0;
    exp_q.delete();
  endtask

  task automatic m_load();
    if (m_full) begin
      m_cur = mask_word(m_hold, bitnum);
    end else begin
      m_und = 1;
`ifndef I2S_SER_UNDERRUN_REPEAT_EN
      m_cur = '0;
`endif
    end
    m_full = 0;
    exp_q.push_back(m_cur);
  endtask

  task automatic m_step();
    bit acc;
    acc   = valid && !m_full;
    m_und = 0;
    if (!m_run) begin
      if (en) begin
        m_run = 1; m_cnt = 0; m_prev_ok = 0;
        m_load();
      end
    end else if (m_cnt == FrameClk - 1) begin
      // Stops only if en was low on this edge and the one before it.
      if (!en && !m_en_prev) begin
        m_run = 0; m_cnt = 0;
      end else begin
        m_prev_ok = 1; m_prev_b0 = m_cur[0]; m_cnt = 0;
        m_load();
      end
    end else begin
      m_cnt++;
    end
    if (acc) begin
      m_hold = data;
      m_full = 1;
    end
    m_en_prev = en;
  endtask

  // Expected {busy, bck, lrck, sdata, ready, underrun}
  function automatic logic [5:0] m_outs();
    int   k;
    logic sd;
    if (!m_run) return {5'b00000, 1'b0} | {4'b0000, !m_full, 1'b0};
    k  = m_cnt / BckClk;
    sd = (k == 0) ? (m_prev_ok ? m_prev_b0 : 1'b0) : m_cur[6'(64 - k)];
    return {1'b1, (m_cnt % BckClk) >= BckHalf, k >= 32, sd, !m_full, m_und};
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) m_reset();
      else m_step();
    end
  end

  // Per-cycle pin checker
  initial begin
    logic [5:0] got, want;
    forever begin
      @(negedge clk);
      got  = {busy, bck, lrck, sdata, ready, underrun};
      want = m_outs();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL cycle pins t=%0t: got %b want %b (busy bck lrck sdata ready underrun)",
                 $time, got, want);
      end
    end
  end

  // I2S receiver: samples on BCK rising edges and rebuilds frames
  initial begin
    int          nb;
    logic [63:0] sr, w;
    logic        r_lrck, bck_p, busy_p;
    nb = -1; sr = '0; w = '0; r_lrck = 0; bck_p = 0; busy_p = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        nb = -1; r_lrck = 0; bck_p = 0; busy_p = 0;
      end else begin
        if (bck && !bck_p) begin
          if (nb < 0) begin
            nb = 0;  // k=0 slot after a start carries no data
          end else begin
            sr = {sr[62:0], sdata};
            nb++;
            if (r_lrck && !lrck) begin
              checks++;
              if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL frame data: got %h, want no frame", sr);
              end else begin
                w = exp_q.pop_front();
                if (nb != 64 || sr !== w) begin
                  errors++;
                  $display("FAIL frame data: got %h (%0d bits) want %h (64 bits)", sr, nb, w);
                end
              end
              nb = 0;
            end
          end
          r_lrck = lrck;
        end
        // A stopped frame never sends its final LSB; compare the 63 bits sent.
        if (busy_p && !busy) begin
          if (nb == 63) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL stopped frame: got %h, want no frame", sr[62:0]);
            end else begin
              w = exp_q.pop_front();
              if (sr[62:0] !== w[63:1]) begin
                errors++;
                $display("FAIL stopped frame: got %h want %h", sr[62:0], w[63:1]);
              end
            end
          end
          nb = -1;
        end
        bck_p  = bck;
        busy_p = busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check6(input string name, input logic [5:0] want);
    logic [5:0] got;
    got = {busy, bck, lrck, sdata, ready, underrun};
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b (busy bck lrck sdata ready underrun)", name, got, want);
    end
  endtask

  task automatic wait_k(input int k);
    int budget;
    budget = 2 * FrameClk;
    while (!(m_run && m_cnt == k * BckClk) && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL wait_k: bit %0d not reached, got cnt %0d", k, m_cnt);
    end
  endtask

  task automatic wait_idle();
    int budget;
    budget = 2 * FrameClk;
    while (busy && budget > 0) begin
      tick();
      budget--;
    end
    checks++;
    if (budget == 0) begin
      errors++;
      $display("FAIL wait_idle: got busy=1 after %0d clk, want 0", 2 * FrameClk);
    end
  endtask

  task automatic run_cycles(input int n, input int rate);
    for (int i = 0; i < n; i++) begin
      valid  = (rate == 2) || (rate == 1 && $urandom_range(0, 7) == 0);
      data   = {$urandom, $urandom};
      bitnum = 2'($urandom_range(0, 3));
      tick();
    end
  endtask

  initial begin
    repeat (3) tick();
    check6("reset values", 6'b000010);
    resetn = 1;
    tick();

    // Directed: one 32-bit word loaded from idle, then an underrun frame
    valid = 1; bitnum = 2'b10; data = 64'hA5A5_0001_8000_00FF;
    tick();
    valid = 0;
    check6("ready after accept", 6'b000000);
    en = 1;
    repeat (FrameClk) tick();
    // This word lands on the load edge of frame 2, so it waits for frame 3
    valid = 1; data = '1; bitnum = 2'b00;
    tick();
    valid = 0;
    repeat (2 * FrameClk) tick();

    // Randomized traffic: idle source, sparse source, or valid held high
    for (int f = 0; f < 12; f++) run_cycles(FrameClk, $urandom_range(0, 2));

    // Stop at k=10 with an empty holding register
    valid = 0;
    tick();
    wait_k(0);
    wait_k(10);
    en = 0;
    wait_idle();
    repeat (5) tick();
    check6("idle after stop", 6'b000010);

    // Restart, drop en at k=10 and restore it at k=40: frames stay continuous
    en = 1; valid = 1; data = {$urandom, $urandom}; bitnum = 2'b01;
    tick();
    valid = 0;
    wait_k(10);
    en = 0;
    wait_k(40);
    en = 1;
    wait_k(2);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL resumed busy: got %b want 1", busy);
    end
    run_cycles(FrameClk, 1);

    // Asynchronous reset at k=20, checked before any clk edge
    wait_k(20);
    #1;
    resetn = 0;
    #1;
    check6("async reset", 6'b000010);
    tick();
    tick();
    resetn = 1;
    run_cycles(2 * FrameClk, 1);

    // Drain: stop and confirm every expected frame was received
    valid = 0; en = 0;
    wait_idle();
    repeat (10) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d frames not received, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
